// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven single-word read/write initiator on the PicoRV32 native bus
module uart_bus_master #(
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ = 8'h52,
  parameter logic [7:0] RSP_ACK = 8'h4B,
  parameter logic [7:0] RSP_NAK = 8'h3F,
  parameter logic [7:0] RSP_TMO = 8'h54,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, MEM, RESP} state_t;
  state_t state_q, state_d;
  logic wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_q, rsp_d;
  logic tx_valid_d, bus_req_d, mem_valid_d;
  logic [7:0] tx_data_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0] mem_wstrb_d;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  assign mem_instr = 1'b0;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rsp_d = rsp_q;
    tx_valid_d = tx_valid;
    tx_data_d = tx_data;
    bus_req_d = bus_req;
    mem_valid_d = mem_valid;
    mem_addr_d = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    tmo_d = tmo_q;
`endif
    case (state_q)
      IDLE: if (rx_valid) begin
        wr_d = rx_data == CMD_WRITE;
        cnt_d = 2'd0;
        if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_d = ADDR;
        else begin
          state_d = RESP;
          tx_valid_d = 1'b1;
          tx_data_d = RSP_NAK;
          cnt_d = 2'd3;
        end
      end
      ADDR: if (rx_valid) begin
        addr_d = {addr_q[23:0], rx_data};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = wr_q ? DATA : REQ;
          bus_req_d = !wr_q;
        end
      end
      DATA: if (rx_valid) begin
        wdata_d = {wdata_q[23:0], rx_data};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = REQ;
          bus_req_d = 1'b1;
        end
      end
      REQ: if (bus_gnt) begin
        state_d = MEM;
        mem_valid_d = 1'b1;
        mem_addr_d = {addr_q[31:2], 2'b00};
        mem_wdata_d = wdata_q;
        mem_wstrb_d = {4{wr_q}};
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      MEM: begin
        if (mem_ready) begin
          state_d = RESP;
          mem_valid_d = 1'b0;
          bus_req_d = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d = wr_q ? RSP_ACK : mem_rdata[31:24];
          rsp_d = {mem_rdata[23:0], 8'h00};
          cnt_d = wr_q ? 2'd3 : 2'd0;
        end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          mem_valid_d = 1'b0;
          bus_req_d = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d = RSP_TMO;
          cnt_d = 2'd3;
        end
        else tmo_d = tmo_q + 1'b1;
`endif
      end
      RESP: if (tx_ready) begin
        cnt_d = cnt_q + 2'd1;
        tx_data_d = rsp_q[31:24];
        rsp_d = {rsp_q[23:0], 8'h00};
        if (cnt_q == 2'd3) begin
          tx_valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_q <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      bus_req <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      busy <= 1'b0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rsp_q <= rsp_d;
      tx_valid <= tx_valid_d;
      tx_data <= tx_data_d;
      bus_req <= bus_req_d;
      mem_valid <= mem_valid_d;
      mem_addr <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      busy <= state_d != IDLE;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed and randomized command streams against a transaction-level reference model
module tb_uart_bus_master;
  logic clk = 1'b0;
  logic reset, rx_valid, tx_ready, bus_gnt, mem_ready;
  logic [7:0] rx_data;
  logic [31:0] mem_rdata;
  logic tx_valid, bus_req, mem_valid, mem_instr, busy;
  logic [7:0] tx_data;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int total = 0;
  int bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int tx_cycles;
  always #5 clk = ~clk;
  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    send(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send(a[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) send(d[8*i +: 8]);
  endtask
  task automatic model(input logic wr, input logic [31:0] rd, output logic [3:0] strb);
    strb = wr ? 4'hF : 4'h0;
    exp_q.delete();
    if (wr) exp_q.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) exp_q.push_back(8'((rd >> (8 * (3 - i))) & 32'hFF));
  endtask
  task automatic serve_mem(input int dly, input logic [31:0] rd, input logic drop_gnt,
                           input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es, input logic chk_d);
    int n = 0;
    while (!mem_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL mem_valid_wait: mem_valid=%b required 1 within 200 cycles", mem_valid);
      return;
    end
    if (drop_gnt) bus_gnt = 1'b0;
    for (int i = 0; i < dly; i++) begin
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== ea || mem_wstrb !== es || (chk_d && mem_wdata !== ed)) begin
        bad++;
        $display("FAIL mem_hold[%0d]: valid=%b addr=%h wdata=%h strb=%h required 1 %h %h %h",
                 i, mem_valid, mem_addr, mem_wdata, mem_wstrb, ea, ed, es);
      end
      if (i == dly - 1) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    total++;
    if (mem_valid !== 1'b0 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL mem_release: mem_valid=%b bus_req=%b required 0 0", mem_valid, bus_req);
    end
    bus_gnt = 1'b1;
  endtask
  task automatic collect(input int n, input int stall_idx, input int stall_len);
    int cyc = 0;
    int st = 0;
    logic [7:0] held = 8'h00;
    got_q.delete();
    while (got_q.size() < n && cyc < 200) begin
      if (tx_valid) begin
        if (got_q.size() == stall_idx && st < stall_len) begin
          if (st == 0) held = tx_data;
          else begin
            total++;
            if (tx_data !== held) begin
              bad++;
              $display("FAIL tx_stall_hold: tx_data=%h required %h", tx_data, held);
            end
          end
          tx_ready = 1'b0;
          st++;
        end else begin
          tx_ready = 1'b1;
          got_q.push_back(tx_data);
        end
      end else tx_ready = 1'b0;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    tx_cycles = cyc;
    total++;
    if (got_q.size() != n) begin
      bad++;
      $display("FAIL tx_count: got %0d bytes required %0d", got_q.size(), n);
    end
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tx_end: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
    end
  endtask
  task automatic check_bytes(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s byte%0d: got %h required %h", tag, i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                         input int dly, input string tag);
    logic [3:0] es;
    model(wr, rd, es);
    send_cmd(wr, a, d);
    serve_mem(dly, rd, 1'b0, a & 32'hFFFF_FFFC, d, es, wr);
    collect(exp_q.size(), -1, 0);
    check_bytes(tag);
    total++;
    if (tx_cycles != exp_q.size()) begin
      bad++;
      $display("FAIL %s back_to_back: %0d cycles required %0d", tag, tx_cycles, exp_q.size());
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h52;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    total++;
    if ({tx_valid, tx_data, bus_req, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, busy} !== '0) begin
      bad++;
      $display("FAIL reset_values: tx_v=%b tx_d=%h req=%b mv=%b addr=%h wd=%h strb=%h busy=%b required all 0",
               tx_valid, tx_data, bus_req, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_wins_rx: busy=%b required 0", busy);
    end
  endtask
  task automatic test_write;
    logic [3:0] es;
    model(1'b1, 32'h0, es);
    send_cmd(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    total++;
    if (bus_req !== 1'b1 || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_latency1: bus_req=%b mem_valid=%b required 1 0", bus_req, mem_valid);
    end
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL write_latency2: mem_valid=%b required 1", mem_valid);
    end
    serve_mem(3, 32'h0, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, es, 1'b1);
    collect(1, -1, 0);
    check_bytes("write");
  endtask
  task automatic test_read_stall;
    logic [3:0] es;
    model(1'b0, 32'h1234_5678, es);
    send_cmd(1'b0, 32'h2000_0008, 32'h0);
    serve_mem(1, 32'h1234_5678, 1'b0, 32'h2000_0008, 32'h0, es, 1'b0);
    collect(4, 1, 5);
    check_bytes("read_stall");
  endtask
  task automatic test_bad_cmd;
    exp_q.delete();
    exp_q.push_back(8'h3F);
    send(8'h41);
    total++;
    if (bus_req !== 1'b0 || tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL bad_cmd: bus_req=%b tx_valid=%b required 0 1", bus_req, tx_valid);
    end
    collect(1, -1, 0);
    check_bytes("bad_cmd");
    run_txn(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 2, "after_bad");
  endtask
  task automatic test_gnt_low;
    logic [3:0] es;
    logic [31:0] rd = $urandom;
    int errs = 0;
    model(1'b0, rd, es);
    bus_gnt = 1'b0;
    send_cmd(1'b0, 32'h3000_00A7, 32'h0);
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_valid !== 1'b0 || bus_req !== 1'b1 || busy !== 1'b1) errs++;
      rx_valid = i[0];
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    mem_ready = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL gnt_low_wait: %0d bad cycles required 0", errs);
    end
    bus_gnt = 1'b1;
    serve_mem(3, rd, 1'b1, 32'h3000_00A4, 32'h0, es, 1'b0);
    collect(4, -1, 0);
    check_bytes("gnt_low");
  endtask
  task automatic test_reset_abort;
    int n = 0;
    send_cmd(1'b1, 32'h4000_0000, 32'h5555_AAAA);
    while (!mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (mem_valid !== 1'b0 || bus_req !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: mv=%b req=%b tx_v=%b busy=%b required 0 0 0 0",
               mem_valid, bus_req, tx_valid, busy);
    end
  endtask
  task automatic test_timeout;
    int n = 0;
    int hi = 0;
    send_cmd(1'b1, 32'h5000_0010, 32'h0BAD_F00D);
    while (!mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    while (mem_valid && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    total++;
    if (hi != 16) begin
      bad++;
      $display("FAIL timeout_len: mem_valid high %0d cycles required 16", hi);
    end
    exp_q.delete();
    exp_q.push_back(8'h54);
    collect(1, -1, 0);
    check_bytes("timeout");
`else
    repeat (1000) @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || bus_req !== 1'b1) begin
      bad++;
      $display("FAIL no_timeout: mem_valid=%b bus_req=%b required 1 1 after 1000 cycles", mem_valid, bus_req);
    end
    exp_q.delete();
    exp_q.push_back(8'h4B);
    serve_mem(1, 32'h0, 1'b0, 32'h5000_0010, 32'h0BAD_F00D, 4'hF, 1'b1);
    collect(1, -1, 0);
    check_bytes("no_timeout");
`endif
    hi = n;
  endtask
  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      if (i != 0 && $urandom_range(0, 7) == 0) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'h3F);
        send(b);
        collect(1, -1, 0);
        check_bytes("rand_bad");
      end else begin
        logic wr = (i == 0) ? 1'b1 : 1'($urandom);
        logic [31:0] a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
        logic [31:0] d = (i == 0) ? 32'hFFFF_FFFF : $urandom;
        run_txn(wr, a, d, $urandom, $urandom_range(1, 4), wr ? "rand_wr" : "rand_rd");
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b0;
    bus_gnt = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    test_reset;
    test_write;
    test_read_stall;
    test_bad_cmd;
    test_gnt_low;
    test_reset_abort;
    test_random;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug bridge: takes a byte stream from the UART receiver and becomes a second initiator on the native PicoRV32 memory bus.
- Decodes single-word read/write commands, drives mem_valid/mem_addr/mem_wdata/mem_wstrb, waits for mem_ready, and returns response bytes to the UART transmitter.
- Sits beside the CPU; a top-level arbiter grants the bus via bus_req/bus_gnt.
- Used for board bring-up and firmware loading without CPU involvement.

Parameters:
CMD_WRITE, 8'h57, command byte for a word write ('W')
CMD_READ, 8'h52, command byte for a word read ('R')
RSP_ACK, 8'h4B, write-complete response ('K')
RSP_NAK, 8'h3F, unknown-command response ('?')
RSP_TMO, 8'h54, bus-timeout response ('T')
TIMEOUT_CYCLES, 1024, mem_ready wait limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  response byte available
tx_data  out  8  response byte
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
bus_req  out  1  request bus ownership from the arbiter
bus_gnt  in  1  bus granted
mem_valid  out  1  native-bus transaction valid
mem_instr  out  1  tied 0
mem_addr  out  32  word address; bits [1:0] forced to 0
mem_wdata  out  32  write data
mem_wstrb  out  4  4'hF for write, 4'h0 for read
mem_ready  in  1  responder completion
mem_rdata  in  32  read data, valid when mem_ready
busy  out  1  high in every state except IDLE

Behaviour:
Interface and reset:
- One clock (clk). Reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values: tx_valid=0, tx_data=0, bus_req=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0. FSM goes to IDLE; byte_cnt=0.
- Reset asserted mid-operation aborts immediately: mem_valid and bus_req drop on the next edge even if mem_ready is never seen; any pending tx byte is discarded.

States:
- IDLE: on rx_valid:
  - rx_data==CMD_WRITE -> ADDR, op=W.
  - rx_data==CMD_READ -> ADDR, op=R.
  - Any other byte -> RESP, loading RSP_NAK.
- ADDR: accept 4 bytes, MSB first, into an address shift register.
  - After the 4th byte: W -> DATA; R -> REQ.
  - byte_cnt is 2 bits and wraps 3->0.
- DATA: accept 4 bytes, MSB first, into wdata, then -> REQ.
- REQ: bus_req=1; on bus_gnt -> MEM.
  - mem_valid rises on the edge after bus_gnt is sampled high.
  - mem_addr={addr[31:2],2'b00}; wstrb=F (W) or 0 (R).
- MEM: mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready is sampled high.
  - On that edge: mem_valid=0, bus_req=0, and rdata is captured for R.
  - W -> RESP with RSP_ACK (1 byte).
  - R -> RESP with 4 bytes, rdata MSB first.
- RESP: tx_valid=1 with tx_data stable until tx_ready.
  - Each accepted byte advances byte_cnt.
  - After the last byte: tx_valid=0 -> IDLE.

Timing and boundary rules:
- Minimum latency from the last command byte to mem_valid: 2 cycles with bus_gnt already high.
- tx_valid may stay high back-to-back across the 4 read bytes; the next byte is presented on the cycle after acceptance.
- rx_valid in REQ, MEM or RESP is dropped silently; no buffering.
- rx_valid in IDLE coincident with reset: reset wins.
- bus_gnt falling while mem_valid=1 is ignored; the transaction completes.
- mem_ready while mem_valid=0 is ignored.
- Address 0xFFFFFFFC and wdata 0xFFFFFFFF are passed unchanged; no arithmetic beyond the shift registers.

Optional Feature:
UART_BUS_MASTER_TIMEOUT_EN
- Defined: a counter clears on entry to MEM and increments each cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES-1 with no mem_ready: mem_valid=0, bus_req=0 on the next edge -> RESP with the single byte RSP_TMO.
  - For reads, no data bytes are sent.
  - mem_ready on the same cycle as expiry counts as success.
- Undefined: no counter; MEM waits indefinitely; RSP_TMO is never produced.

Test Plan:
1. Write: rx 57 10 00 00 04 DE AD BE EF, bus_gnt=1, mem_ready 3 cycles after mem_valid -> mem_addr=0x10000004, mem_wdata=0xDEADBEEF, mem_wstrb=F held 3 cycles; tx 4B.
2. Read: rx 52 20 00 00 08, mem_rdata=0x12345678 with ready -> mem_wstrb=0; tx 12 34 56 78; tx_ready stalled 5 cycles on byte 2 keeps tx_data=34 stable.
3. Bad command 0x41 -> no bus_req; tx 3F; returns to IDLE; a following valid read succeeds.
4. bus_gnt held low 20 cycles in REQ -> mem_valid stays 0, bus_req=1; stray rx bytes ignored; completes normally after grant.
5. Reset pulse while mem_valid=1 -> next cycle mem_valid=0, bus_req=0, tx_valid=0, busy=0.
6. With UART_BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready never asserted -> mem_valid drops after 16 cycles; tx 54. Without the macro -> mem_valid still high after 1000 cycles.
